// File: rtl/read_return_serializer_pkg.sv
// Shared types for the read-return serializer: buffered entry layout and FSM states.
package read_return_serializer_pkg;

   localparam int RR_FE_WORD_W = 32;
   localparam int RR_BEATS     = 4;
   localparam int RR_ID_W      = 4;
   localparam int RR_CORE_W    = 2;
   localparam int RR_DEPTH     = 4;

   typedef struct packed {
      logic [RR_BEATS*RR_FE_WORD_W-1:0] data;
      logic [RR_ID_W-1:0]               request_id;
      logic [RR_CORE_W-1:0]             core_num;
   } read_return_entry_t;

   typedef enum logic {
      RR_IDLE = 1'b0,
      RR_SEND = 1'b1
   } rr_state_e;

endpackage

// File: rtl/read_return_serializer_fifo.sv
// read_return_fifo: synchronous return-word buffer, DEPTH deep (power of 2).
// Exposes the entry behind the head so the serializer can chain words without a bubble.
module read_return_fifo
   import read_return_serializer_pkg::*;
#(
   parameter int  DEPTH   = RR_DEPTH,
   parameter type entry_t = read_return_entry_t
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_wr_en,
   input  entry_t                     i_wr_data,
   input  logic                       i_rd_en,
   output entry_t                     o_data,
   output entry_t                     o_data_next,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   entry_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_wr;
   logic            w_rd;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_wr    = i_wr_en && !o_full;
   assign w_rd    = i_rd_en && !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data      = r_mem[r_rd_ptr];
   assign o_data_next = r_mem[r_rd_ptr + AW'(1)];

endmodule

// File: rtl/read_return_serializer.sv
// Splits buffered backend read words into frontend beats (MSB slice first) with a last flag.
// Optional perf counters are built when READ_RETURN_PERF_EN is defined.
//
// state   | meaning
// RR_IDLE | no beat presented; load the FIFO head when one is present
// RR_SEND | a word is being presented beat by beat; pop on its last handshake
module read_return_serializer
   import read_return_serializer_pkg::*;
#(
   parameter int FE_WORD_W = RR_FE_WORD_W,
   parameter int BEATS     = RR_BEATS,
   parameter int ID_W      = RR_ID_W,
   parameter int CORE_W    = RR_CORE_W,
   parameter int DEPTH     = RR_DEPTH
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   output logic                       o_frontend_receive_ready,
   input  logic                       i_returned_data_valid,
   input  logic [BEATS*FE_WORD_W-1:0] i_returned_data,
   input  logic [ID_W-1:0]            i_returned_request_id,
   input  logic [CORE_W-1:0]          i_returned_core_num,
   input  logic                       i_interconnection_ready,
   output logic                       o_scheduler_request_valid,
   output logic [FE_WORD_W-1:0]       o_scheduler_read_data,
   output logic                       o_scheduler_read_data_last,
   output logic [ID_W-1:0]            o_scheduler_request_id,
   output logic [CORE_W-1:0]          o_scheduler_core_num
`ifdef READ_RETURN_PERF_EN
   ,
   output logic [15:0]                o_perf_word_cnt,
   output logic [15:0]                o_perf_stall_cnt
`endif
);

   localparam int WORD_W = BEATS * FE_WORD_W;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [ID_W-1:0]   request_id;
      logic [CORE_W-1:0] core_num;
   } entry_t;

   entry_t            w_push_entry;
   entry_t            w_head;
   entry_t            w_head_next;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic              w_push;
   logic              w_hs;
   logic              w_pop;
   logic              w_load_head;
   logic              w_load_next;
   logic              w_advance;
   logic              w_drop;
   rr_state_e         r_state;
   rr_state_e         w_state_nxt;

   logic              r_valid;
   logic [WORD_W-1:0] r_word;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic [ID_W-1:0]   r_id;
   logic [CORE_W-1:0] r_core;

   assign o_frontend_receive_ready = !w_full;
   assign w_push       = i_returned_data_valid && o_frontend_receive_ready;
   assign w_push_entry = '{data: i_returned_data, request_id: i_returned_request_id,
                           core_num: i_returned_core_num};

   read_return_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (w_push),
      .i_wr_data   (w_push_entry),
      .i_rd_en     (w_pop),
      .o_data      (w_head),
      .o_data_next (w_head_next),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   assign w_hs = r_valid && i_interconnection_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load_head = 1'b0;
      w_load_next = 1'b0;
      w_advance   = 1'b0;
      w_drop      = 1'b0;
      w_pop       = 1'b0;
      unique case (r_state)
         RR_IDLE: begin
            if (!w_empty) begin
               w_load_head = 1'b1;
               w_state_nxt = RR_SEND;
            end
         end
         RR_SEND: begin
            if (w_hs) begin
               if (r_beat_cnt != LAST_BEAT) begin
                  w_advance = 1'b1;
               end else begin
                  w_pop = 1'b1;
                  // The entry behind the head was written earlier, so it can chain directly.
                  if (w_count > CW'(1)) begin
                     w_load_next = 1'b1;
                  end else begin
                     w_drop      = 1'b1;
                     w_state_nxt = RR_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = RR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= RR_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid    <= 1'b0;
         r_word     <= '0;
         r_beat_cnt <= '0;
         r_id       <= '0;
         r_core     <= '0;
      end else if (w_load_head || w_load_next) begin
         r_valid    <= 1'b1;
         r_word     <= w_load_head ? w_head.data       : w_head_next.data;
         r_id       <= w_load_head ? w_head.request_id : w_head_next.request_id;
         r_core     <= w_load_head ? w_head.core_num   : w_head_next.core_num;
         r_beat_cnt <= '0;
      end else if (w_advance) begin
         r_word     <= r_word << FE_WORD_W;
         r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end else if (w_drop) begin
         r_valid    <= 1'b0;
         r_beat_cnt <= '0;
      end
   end

   assign o_scheduler_request_valid  = r_valid;
   assign o_scheduler_read_data      = r_word[WORD_W-1 -: FE_WORD_W];
   assign o_scheduler_read_data_last = r_valid && (r_beat_cnt == LAST_BEAT);
   assign o_scheduler_request_id     = r_id;
   assign o_scheduler_core_num       = r_core;

`ifdef READ_RETURN_PERF_EN
   logic [15:0] r_perf_word_cnt;
   logic [15:0] r_perf_stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perf_word_cnt  <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_pop && (r_perf_word_cnt != 16'hFFFF))
            r_perf_word_cnt <= r_perf_word_cnt + 16'd1;
         if (r_valid && !i_interconnection_ready && (r_perf_stall_cnt != 16'hFFFF))
            r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
      end
   end

   assign o_perf_word_cnt  = r_perf_word_cnt;
   assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
